// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH split into STAGES segments, BLOCK-bit lookahead groups per segment.
// Latency: STAGES register stages; an operand accepted at edge N is presented as out_valid after edge N+STAGES-1.
// Backpressure: whole pipe advances only when the output slot is empty or being taken; otherwise every stage holds.
// Optional feature macro CLA_SAT_EN: clamp sum to signed max/min on overflow (default build wraps modulo 2^WIDTH).
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / BLOCK;

    // Segment k of x+y+ci. Returns {carry into segment MSB, carry out, segment sum}.
    // Every carry is a sum-of-products of g/p terms: group G/P inside each block,
    // group carries from a second lookahead level, bit carries from their group carry.
    function automatic logic [SEG+1:0] cla_seg(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             ci,
                                               input int               k);
        logic [SEG-1:0]  g;
        logic [SEG-1:0]  p;
        logic [NGRP-1:0] gg;
        logic [NGRP-1:0] gp;
        logic [NGRP:0]   gc;
        logic [SEG:0]    c;
        logic            t;
        for (int i = 0; i < SEG; i++) begin
            g[i] = x[k*SEG+i] & y[k*SEG+i];
            p[i] = x[k*SEG+i] ^ y[k*SEG+i];
        end
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int o = 0; o < BLOCK; o++) begin
                gp[j] = gp[j] & p[j*BLOCK+o];
                t = g[j*BLOCK+o];
                for (int l = o + 1; l < BLOCK; l++) t = t & p[j*BLOCK+l];
                gg[j] = gg[j] | t;
            end
        end
        for (int j = 0; j <= NGRP; j++) begin
            t = ci;
            for (int l = 0; l < j; l++) t = t & gp[l];
            gc[j] = t;
            for (int m = 0; m < j; m++) begin
                t = gg[m];
                for (int l = m + 1; l < j; l++) t = t & gp[l];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NGRP; j++) begin
            for (int o = 0; o < BLOCK; o++) begin
                t = gc[j];
                for (int l = 0; l < o; l++) t = t & p[j*BLOCK+l];
                c[j*BLOCK+o] = t;
                for (int m = 0; m < o; m++) begin
                    t = g[j*BLOCK+m];
                    for (int l = m + 1; l < o; l++) t = t & p[j*BLOCK+l];
                    c[j*BLOCK+o] = c[j*BLOCK+o] | t;
                end
            end
        end
        c[SEG] = gc[NGRP];
        return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic              pipe_en;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bb_q  [STAGES];
    logic [WIDTH-1:0]  bb_d  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;
    logic [SEG+1:0]    seg_r;

    // Stage sources, per-segment lookahead add, final-stage flags and optional clamp.
    always_comb begin
        pipe_en    = !vld_q[STAGES-1] | out_ready;
        in_ready   = pipe_en & !rst;
        seg_r      = '0;
        src_a[0]   = a;
        src_b[0]   = sub ? ~b : b;
        src_c[0]   = sub ? ~cin : cin;
        src_sum[0] = '0;
        src_v[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_b[k]   = bb_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_c[k]   = c_q[k-1];
            src_v[k]   = vld_q[k-1];
        end
        vld_d  = vld_q;
        c_d    = c_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            bb_d[k]  = bb_q[k];
            sum_d[k] = sum_q[k];
        end
        if (pipe_en) begin
            for (int k = 0; k < STAGES; k++) begin
                seg_r                   = cla_seg(src_a[k], src_b[k], src_c[k], k);
                a_d[k]                  = src_a[k];
                bb_d[k]                 = src_b[k];
                sum_d[k]                = src_sum[k];
                sum_d[k][k*SEG +: SEG]  = seg_r[SEG-1:0];
                c_d[k]                  = seg_r[SEG];
                vld_d[k]                = src_v[k];
                if (k == STAGES - 1) begin
                    ovf_d = seg_r[SEG+1] ^ seg_r[SEG];
`ifdef CLA_SAT_EN
                    // Clamp direction follows the sign of A (both operands share it on overflow).
                    if (ovf_d) begin
                        sum_d[k] = src_a[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    zero_d = ~|sum_d[k];
                end
            end
        end
    end

    // Pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bb_q[k]  <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                bb_q[k]  <= bb_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH=32, BLOCK=4, STAGES=2.
// Vector table for arithmetic/flags, plus sequences for backpressure and reset mid-flight.
// Expected values follow the CLA_SAT_EN macro when it is defined for the build.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int n_pass  = 0;
    int n_total = 0;

    cla_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        logic        e_zero;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] bp_a   [4];
        logic [31:0] bp_b   [4];
        logic [31:0] bp_exp [4];
        int          sent;
        int          recv;
        int          cyc;
        bit          saw_stall;
        bit          held_prev;
        logic [31:0] held_sum;
        bit          ghost;

        //            a             b             cin   sub   sum           cout  ovf   zero
        vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
`ifdef CLA_SAT_EN
        vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
        vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
`endif
        vecs[3]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, zero}, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Table: one op at a time, checking latency and all outputs.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_early", i), out_valid, 0);
            @(posedge clk); #2;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].e_sum);
            chk($sformatf("v%0d_cout", i), cout, vecs[i].e_cout);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].e_ovf);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].e_zero);
        end

        // Backpressure: 4 back-to-back ops, out_ready low for 3 cycles mid-stream.
        for (int i = 0; i < 4; i++) begin
            bp_a[i]   = 32'h1000_0000 * i + 32'h0000_FFFF;
            bp_b[i]   = 32'h0000_0001 + i;
            bp_exp[i] = bp_a[i] + bp_b[i];
        end
        sent = 0; recv = 0; cyc = 0; saw_stall = 1'b0; held_prev = 1'b0; held_sum = '0;
        cin = 1'b0; sub = 1'b0;
        @(posedge clk);
        while (recv < 4 && cyc < 40) begin
            #1;
            out_ready = !(cyc >= 2 && cyc < 5);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                a = bp_a[sent]; b = bp_b[sent];
            end
            #1;
            if (held_prev) chk("bp_hold_sum", sum, held_sum);
            held_prev = out_valid && !out_ready;
            held_sum  = sum;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_sum%0d", recv), sum, bp_exp[recv]);
                recv++;
            end
            cyc++;
            @(posedge clk);
        end
        chk("bp_recv_count", recv, 4);
        chk("bp_in_ready_dropped", saw_stall, 1);
        #1; in_valid = 1'b0; out_ready = 1'b1;
        ghost = 1'b0;
        repeat (3) begin
            #1;
            if (out_valid) ghost = 1'b1;
            @(posedge clk); #1;
        end
        chk("bp_no_dup", ghost, 0);

        // Reset with two ops in flight.
        @(posedge clk); #1;
        a = 32'h0000_0011; b = 32'h0000_0022; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h0000_0033; b = 32'h0000_0044;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #2;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_in_ready", in_ready, 0);
        #1; rst = 1'b0;
        ghost = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
            if (out_valid) ghost = 1'b1;
        end
        chk("rstmid_no_stale", ghost, 0);

        // Pipe still works after the reset.
        @(posedge clk); #1;
        a = 32'h0000_0005; b = 32'h0000_0003; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sum", sum, 32'h0000_0008);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
